// File: rtl/btn_uart_reporter.sv
// btn_uart_reporter: reports each debounced button press as "BTN hh\r\n" over an 8N1 UART.
// Define BTN_UART_RELEASE_MSG_EN to also report release edges as "REL hh\r\n".
module btn_uart_reporter #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button_in,
    output logic       tx,
    output logic       busy,
    output logic [7:0] press_count
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic          r_btn_q;
    logic          r_press_pend;
    logic          r_tx;
    logic          r_busy;
    logic [7:0]    r_count;
    logic [7:0]    r_snap;
    logic [2:0]    r_state;
    logic [2:0]    r_byte_idx;
    logic [2:0]    r_bit_idx;
    logic [CW-1:0] r_clk_cnt;
    logic [7:0]    w_byte;
    logic          w_press;
    logic          w_pend;
    logic          w_is_rel;
    logic          w_load;
    logic          w_bit_end;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
    endfunction

    assign w_press     = button_in & ~r_btn_q;
    assign w_load      = r_state == S_LOAD;
    assign w_bit_end   = r_clk_cnt == CW'(CPB - 1);
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign press_count = r_count;

`ifdef BTN_UART_RELEASE_MSG_EN
    logic r_rel_pend;
    logic r_is_rel;

    assign w_pend   = r_press_pend | r_rel_pend;
    assign w_is_rel = r_is_rel;

    // Press outranks release when both are waiting at LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rel_pend <= 1'b0;
            r_is_rel   <= 1'b0;
        end else begin
            r_rel_pend <= (~button_in & r_btn_q) | (r_rel_pend & ~(w_load & ~r_press_pend));
            if (w_load)
                r_is_rel <= ~r_press_pend;
        end
    end
`else
    assign w_pend   = r_press_pend;
    assign w_is_rel = 1'b0;
`endif

    always_comb begin
        w_byte = 8'h0A;
        case (r_byte_idx)
            3'd0:    w_byte = w_is_rel ? 8'h52 : 8'h42;
            3'd1:    w_byte = w_is_rel ? 8'h45 : 8'h54;
            3'd2:    w_byte = w_is_rel ? 8'h4C : 8'h4E;
            3'd3:    w_byte = 8'h20;
            3'd4:    w_byte = hex(r_snap[7:4]);
            3'd5:    w_byte = hex(r_snap[3:0]);
            3'd6:    w_byte = 8'h0D;
            default: w_byte = 8'h0A;
        endcase
    end

    // A new press on the LOAD edge wins over the clear, keeping the one-deep queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_q      <= 1'b0;
            r_count      <= '0;
            r_press_pend <= 1'b0;
        end else begin
            r_btn_q      <= button_in;
            r_count      <= r_count + {7'd0, w_press};
            r_press_pend <= w_press | (r_press_pend & ~w_load);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_snap     <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_clk_cnt  <= '0;
        end else begin
            r_clk_cnt <= (r_state == S_IDLE || w_load || w_bit_end) ? '0 : r_clk_cnt + CW'(1);
            case (r_state)
                S_IDLE: if (w_pend) r_state <= S_LOAD;
                S_LOAD: begin
                    r_snap     <= r_count;
                    r_byte_idx <= '0;
                    r_tx       <= 1'b0;
                    r_busy     <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: if (w_bit_end) begin
                    r_bit_idx <= '0;
                    r_tx      <= w_byte[0];
                    r_state   <= S_DATA;
                end
                S_DATA: if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_bit_idx <= r_bit_idx + 3'd1;
                        r_tx      <= w_byte[r_bit_idx + 3'd1];
                    end
                end
                S_STOP: if (w_bit_end) begin
                    if (r_byte_idx == 3'd7) begin
                        r_busy  <= 1'b0;
                        r_state <= w_pend ? S_LOAD : S_IDLE;
                    end else begin
                        r_byte_idx <= r_byte_idx + 3'd1;
                        r_tx       <= 1'b0;
                        r_state    <= S_START;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_btn_uart_reporter.sv
// tb_btn_uart_reporter: directed bench decoding the serial line back into bytes.
// Reduced baud keeps frames short; all timing is expressed in CPB.
module tb_btn_uart_reporter;
    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int MSG    = 80 * CPB;
`ifdef BTN_UART_RELEASE_MSG_EN
    localparam int REL = 1;
`else
    localparam int REL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button_in;
    logic       tx;
    logic       busy;
    logic [7:0] press_count;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         p;
    int         t;
    int         n;
    int         seen;
    int         dec_s;
    logic [7:0] dec_b;
    logic [7:0] rx_q[$];
    int         st_q[$];

    btn_uart_reporter #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button_in(button_in),
        .tx(tx),
        .busy(busy),
        .press_count(press_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_msg(input string tag, input string s);
        logic [7:0] exp[8];
        for (int i = 0; i < 6; i++) exp[i] = s[i];
        exp[6] = 8'h0D;
        exp[7] = 8'h0A;
        for (int i = 0; i < 8; i++)
            check(tag, rx_q.size() > 0 ? {24'd0, rx_q.pop_front()} : 32'hFFFF_FFFF, {24'd0, exp[i]});
    endtask

    task automatic collect(input string tag, input int cnt);
        int w = 0;
        while (rx_q.size() < cnt && w < (cnt / 8 + 1) * (MSG + 20)) begin
            @(negedge clk);
            w++;
        end
        repeat (MSG + 20) @(negedge clk);
        check(tag, rx_q.size(), cnt);
    endtask

    task automatic pulse();
        @(negedge clk) button_in = 1'b1;
        @(negedge clk) button_in = 1'b0;
    endtask

    task automatic wait_start();
        int w = 0;
        while (tx !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("start_seen", tx, 0);
    endtask

    task automatic clr();
        rx_q.delete();
        st_q.delete();
    endtask

    // Samples each bit mid-cell, starting from the first low sample of a start bit.
    initial forever begin
        @(negedge clk);
        if (tx === 1'b0) begin
            dec_s = cyc;
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                dec_b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            check("stop_bit", tx, 1);
            rx_q.push_back(dec_b);
            st_q.push_back(dec_s);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b1;
        button_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_cnt", press_count, 8'h00);
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) seen = 1;
        end
        check("rst_hold", seen, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        clr();
        // Single press held ~1000 cycles, release after the frame ends.
        @(negedge clk) button_in = 1'b1;
        @(negedge clk);
        p = cyc;
        check("t2_cnt", press_count, 8'h01);
        check("t2_tx_n", tx, 1);
        check("t2_busy_n", busy, 0);
        @(negedge clk);
        check("t2_tx_load", tx, 1);
        check("t2_busy_load", busy, 0);
        @(negedge clk);
        check("t2_tx_start", tx, 0);
        check("t2_busy_start", busy, 1);
        n = 1;
        t = 0;
        while (busy === 1'b1 && t < MSG + 50) begin
            @(negedge clk);
            t++;
            if (busy === 1'b1) n++;
        end
        check("t2_busy_len", n, MSG);
        while (cyc < p + 1000) @(negedge clk);
        button_in = 1'b0;
        collect("t2_bytes", 8 * (1 + REL));
        if (st_q.size() >= 8) begin
            check("t2_latency", st_q[0], p + 2);
            check("t2_bits", st_q[7] - st_q[0], 70 * CPB);
        end
        check_msg("t2_btn", "BTN 01");
`ifdef BTN_UART_RELEASE_MSG_EN
        check_msg("t2_rel", "REL 01");
`endif
        clr();
        // Reset during byte 3 data bit 3 (a zero bit of ' ').
        pulse();
        wait_start();
        repeat (34 * CPB) @(negedge clk);
        check("t5_tx_pre", tx, 0);
        rst_n = 1'b0;
        #1;
        check("t5_tx_rst", tx, 1);
        check("t5_busy_rst", busy, 0);
        check("t5_cnt_rst", press_count, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (2 * MSG) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) seen = 1;
        end
        check("t5_quiet", seen, 0);
        clr();
        // One press starts a frame, three more arrive while it is sent.
        pulse();
        wait_start();
        repeat (100) @(negedge clk);
        repeat (3) begin
            repeat (10) @(negedge clk);
            pulse();
        end
        check("t3_cnt", press_count, 8'h04);
        collect("t3_bytes", 8 * (2 + REL));
        if (st_q.size() >= 9) check("t3_gap", st_q[8] - st_q[0], MSG + 1);
        check_msg("t3_m1", "BTN 01");
        check_msg("t3_m2", "BTN 04");
`ifdef BTN_UART_RELEASE_MSG_EN
        check_msg("t3_m3", "REL 04");
`endif
        clr();
        repeat (167) pulse();
        check("t4_cnt_ab", press_count, 8'hAB);
        collect("t4a_bytes", 8 * (2 + REL));
        check_msg("t4a_m1", "BTN 05");
        check_msg("t4a_m2", "BTN AB");
`ifdef BTN_UART_RELEASE_MSG_EN
        check_msg("t4a_m3", "REL AB");
`endif
        clr();
        repeat (84) pulse();
        check("t4_cnt_ff", press_count, 8'hFF);
        collect("t4b_bytes", 8 * (2 + REL));
        check_msg("t4b_m1", "BTN AC");
        check_msg("t4b_m2", "BTN FF");
`ifdef BTN_UART_RELEASE_MSG_EN
        check_msg("t4b_m3", "REL FF");
`endif
        clr();
        pulse();
        check("t4_cnt_wrap", press_count, 8'h00);
        collect("t4c_bytes", 8 * (1 + REL));
        check_msg("t4c_m1", "BTN 00");
`ifdef BTN_UART_RELEASE_MSG_EN
        check_msg("t4c_m2", "REL 00");
`endif
        check("end_busy", busy, 0);
        check("end_tx", tx, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/btn_uart_reporter.md
# btn_uart_reporter

Event reporter downstream of the button debouncer: takes the debounced, clock-synchronous button level, detects press edges, keeps an 8-bit press counter and reports each press over a built-in 8N1 UART transmitter as the ASCII line "BTN hh\r\n". It gives the board a serial trace of button activity at the 12 MHz system clock.

## Interface
- CLK_HZ, 12_000_000, system clock frequency in Hz
- BAUD, 115_200, serial bit rate; CLKS_PER_BIT = CLK_HZ / BAUD, integer division (104 at defaults)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- button_in  in  1  debounced button level from the debouncer, synchronous to clk, active-high
- tx  out  1  UART serial output, idle high
- busy  out  1  high while a message is being sent
- press_count  out  8  number of presses detected, modulo 256

## Operation
- Edge detect: btn_q registers button_in (reset 0). Press = button_in & ~btn_q.
- On press: press_count increments (wraps 0xFF -> 0x00); press_pend set.
- Message: 8 bytes 'B','T','N',' ', hex high nibble, hex low nibble, 0x0D, 0x0A. Hex digits uppercase ASCII ('0'-'9','A'-'F'). Nibbles come from press_count snapshotted in LOAD.
- FSM: IDLE -> LOAD (pending event present) -> START -> DATA (8 bits, LSB first) -> STOP -> START of next byte, or IDLE after byte 7.
- IDLE: tx=1. LOAD: one cycle, captures snapshot, clears the pending flag being served, byte index = 0.
- START: tx=0 for CLKS_PER_BIT cycles. DATA: each bit CLKS_PER_BIT cycles. STOP: tx=1 for CLKS_PER_BIT cycles.
- Bytes back-to-back, no idle gap between bytes of one message.
- Press during busy: count increments immediately; press_pend set; one message sent after current one ends, reporting count at its LOAD. Further presses while pending only increment count (one-deep queue, no extra messages).
- Reset values: tx=1, busy=0, press_count=0x00, all pending flags 0, FSM IDLE. Reset asserted mid-frame: tx returns high asynchronously, message aborted, nothing resumes after release.

## Timing
- Press sampled at clock edge N (button_in=1, btn_q=0): press_count updates at edge N; FSM enters LOAD at N+1; busy and tx=0 from edge N+2.
- busy stays high until the end of the last stop bit; it falls on the same edge FSM returns to IDLE.
- Message length: 80 x CLKS_PER_BIT cycles (8320 at defaults); one LOAD cycle between back-to-back messages, tx held high there.
- Press and release of a single debounced pulse shorter than one cycle cannot occur (input already debounced); a 1-cycle pulse still counts as one press.

## Configuration
- BTN_UART_RELEASE_MSG_EN defined: falling edge of button_in (~button_in & btn_q) sets rel_pend and produces "REL hh\r\n" (hh = current press_count, count not incremented). Same one-deep rule per event type; if both pending at LOAD, press message goes first.
- Not defined: release edges ignored; only press messages exist; no rel_pend logic.

## Test plan
- Reset: rst_n low -> tx=1, busy=0, press_count=0x00; hold 200 cycles, tx stays 1.
- Single press (button_in 0->1, held 20 000 cycles) -> press_count=0x01, tx low 2 cycles after sampled edge, decoded bytes 42 54 4E 20 30 31 0D 0A, each bit 104 cycles, busy high exactly 8320 cycles.
- Three presses during one message -> press_count=0x04 after third; exactly two messages total: "BTN 01" then "BTN 04", separated by one idle-high cycle.
- Preload 255 presses (spaced >8400 cycles) then one more -> press_count=0x00, message "BTN 00"; 0xAB state reports "BTN AB" (uppercase).
- rst_n pulsed low during DATA of byte 3 -> tx high immediately, busy=0, count=0x00, no further frames until a new press.
- With BTN_UART_RELEASE_MSG_EN: press then release 1000 cycles later -> "BTN 01\r\n" then "REL 01\r\n"; without macro same stimulus -> only "BTN 01\r\n".
